// File: rtl/fifo_dual.sv
// fifo_dual: two-wide in-order FIFO with exact occupancy, all-or-nothing handshakes, almost-full and flush
module fifo_dual #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_LEN  = 4,
  parameter int AF_THRESH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic [1:0]          wr_cnt_i,
  input  logic [WIDTH-1:0]    wr_data0_i,
  input  logic [WIDTH-1:0]    wr_data1_i,
  input  logic [1:0]          rd_cnt_i,
  output logic                wr_ack_o,
  output logic                rd_ack_o,
  output logic [WIDTH-1:0]    rd_data0_o,
  output logic [WIDTH-1:0]    rd_data1_o,
  output logic                rd_valid0_o,
  output logic                rd_valid1_o,
  output logic [ADDR_LEN:0]   count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                almost_full_o
);
  localparam logic [ADDR_LEN:0] L_DEPTH = (ADDR_LEN+1)'(DEPTH);
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_LEN-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_LEN:0]   r_cnt;
  logic [1:0]          w_wr_cnt, w_rd_cnt;
  logic [ADDR_LEN:0]   w_wr_n, w_rd_n, w_free;
  // Handshakes: illegal count 3 collapses to 0; space and data judged on start-of-cycle count
  always_comb begin
    w_wr_cnt = (wr_cnt_i == 2'd3) ? 2'd0 : wr_cnt_i;
    w_rd_cnt = (rd_cnt_i == 2'd3) ? 2'd0 : rd_cnt_i;
    w_wr_n   = {{(ADDR_LEN-1){1'b0}}, w_wr_cnt};
    w_rd_n   = {{(ADDR_LEN-1){1'b0}}, w_rd_cnt};
    w_free   = L_DEPTH - r_cnt;
    wr_ack_o = (w_wr_cnt != 2'd0) && (w_free >= w_wr_n) && !flush_i;
    rd_ack_o = (w_rd_cnt != 2'd0) && (r_cnt >= w_rd_n) && !flush_i;
  end
  assign rd_data0_o    = r_mem[r_rd_ptr];
  assign rd_data1_o    = r_mem[r_rd_ptr + ADDR_LEN'(1)];
  assign count_o       = r_cnt;
  assign empty_o       = r_cnt == '0;
  assign full_o        = r_cnt == L_DEPTH;
  assign almost_full_o = (DEPTH - int'(r_cnt)) < AF_THRESH;
  assign rd_valid0_o   = r_cnt != '0;
  assign rd_valid1_o   = r_cnt > (ADDR_LEN+1)'(1);
  // Storage: not reset, but a write acked during reset is not committed
  always_ff @(posedge clk_i) begin
    if (reset_i && wr_ack_o) begin
      r_mem[r_wr_ptr] <= wr_data0_i;
      if (w_wr_cnt == 2'd2) r_mem[r_wr_ptr + ADDR_LEN'(1)] <= wr_data1_i;
    end
  end
  // Pointers and occupancy; reset and flush both empty the queue
  always_ff @(posedge clk_i) begin
    if (!reset_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (wr_ack_o) r_wr_ptr <= r_wr_ptr + ADDR_LEN'(w_wr_cnt);
      if (rd_ack_o) r_rd_ptr <= r_rd_ptr + ADDR_LEN'(w_rd_cnt);
      r_cnt <= r_cnt + (wr_ack_o ? w_wr_n : '0) - (rd_ack_o ? w_rd_n : '0);
    end
  end
endmodule

// File: tb/tb_fifo_dual.sv
// tb_fifo_dual: directed checks of the two-wide FIFO against a queue model
module tb_fifo_dual;
  logic        clk_i = 1'b0;
  logic        reset_i, flush_i;
  logic [1:0]  wr_cnt_i, rd_cnt_i;
  logic [31:0] wr_data0_i, wr_data1_i, rd_data0_o, rd_data1_o;
  logic        wr_ack_o, rd_ack_o, rd_valid0_o, rd_valid1_o;
  logic [4:0]  count_o;
  logic        empty_o, full_o, almost_full_o;
  logic [31:0] q[$];
  logic [31:0] nxt = 32'h100;
  logic [31:0] x;
  int n_chk = 0;
  int n_fail = 0;

  fifo_dual dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .wr_cnt_i(wr_cnt_i), .wr_data0_i(wr_data0_i), .wr_data1_i(wr_data1_i),
    .rd_cnt_i(rd_cnt_i), .wr_ack_o(wr_ack_o), .rd_ack_o(rd_ack_o),
    .rd_data0_o(rd_data0_o), .rd_data1_o(rd_data1_o),
    .rd_valid0_o(rd_valid0_o), .rd_valid1_o(rd_valid1_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic flags(input string tag);
    int n;
    n = q.size();
    chk({tag, " count"}, 64'(count_o), 64'(n));
    chk({tag, " empty"}, 64'(empty_o), 64'(n == 0));
    chk({tag, " full"}, 64'(full_o), 64'(n == 16));
    chk({tag, " almost_full"}, 64'(almost_full_o), 64'((16 - n) < 2));
    chk({tag, " valid0"}, 64'(rd_valid0_o), 64'(n >= 1));
    chk({tag, " valid1"}, 64'(rd_valid1_o), 64'(n >= 2));
  endtask

  task automatic cyc(input logic [1:0] wc, input logic [1:0] rc, input logic fl,
                     input logic ewa, input logic era, input string tag);
    logic [31:0] d0, d1;
    d0 = nxt;
    d1 = nxt + 32'd1;
    wr_cnt_i = wc; wr_data0_i = d0; wr_data1_i = d1; rd_cnt_i = rc; flush_i = fl;
    #1;
    chk({tag, " wr_ack"}, 64'(wr_ack_o), 64'(ewa));
    chk({tag, " rd_ack"}, 64'(rd_ack_o), 64'(era));
    if (era) begin
      chk({tag, " rd_data0"}, 64'(rd_data0_o), 64'(q[0]));
      if (rc == 2'd2) chk({tag, " rd_data1"}, 64'(rd_data1_o), 64'(q[1]));
    end
    @(posedge clk_i); #1;
    if (fl || !reset_i) q.delete();
    else begin
      if (era) repeat (int'(rc)) void'(q.pop_front());
      if (ewa) begin
        q.push_back(d0);
        if (wc == 2'd2) q.push_back(d1);
        nxt = nxt + 32'(wc);
      end
    end
    wr_cnt_i = 2'd0; rd_cnt_i = 2'd0; flush_i = 1'b0;
    #1;
    flags(tag);
  endtask

  initial begin
    reset_i = 1'b0; flush_i = 1'b0; wr_cnt_i = 2'd0; rd_cnt_i = 2'd0;
    wr_data0_i = '0; wr_data1_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    flags("reset");
    reset_i = 1'b1;
    cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "wr_ab");
    cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "wr_cd");
    chk("pair count", 64'(count_o), 64'd4);
    chk("pair head0", 64'(rd_data0_o), 64'h100);
    chk("pair head1", 64'(rd_data1_o), 64'h101);
    chk("pair valid1", 64'(rd_valid1_o), 64'd1);
    repeat (5) cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "fill");
    cyc(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, "fill15");
    chk("af at 15", 64'(almost_full_o), 64'd1);
    cyc(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, "wr2_at15");
    chk("count held 15", 64'(count_o), 64'd15);
    cyc(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, "wr1_at15");
    chk("full at 16", 64'(full_o), 64'd1);
    cyc(2'd1, 2'd1, 1'b0, 1'b0, 1'b1, "full_rw");
    chk("head after full_rw", 64'(rd_data0_o), 64'h101);
    repeat (7) cyc(2'd0, 2'd2, 1'b0, 1'b0, 1'b1, "drain");
    chk("head at 1", 64'(rd_data0_o), 64'h10F);
    cyc(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, "rd2_at1");
    cyc(2'd0, 2'd1, 1'b0, 1'b0, 1'b1, "rd1_at1");
    chk("empty at 0", 64'(empty_o), 64'd1);
    cyc(2'd1, 2'd1, 1'b0, 1'b1, 1'b0, "empty_rw");
    cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "pre_steady_wr");
    cyc(2'd0, 2'd1, 1'b0, 1'b0, 1'b1, "pre_steady_rd");
    repeat (40) cyc(2'd2, 2'd2, 1'b0, 1'b1, 1'b1, "steady");
    chk("steady count", 64'(count_o), 64'd2);
    cyc(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, "wr_cnt3");
    cyc(2'd0, 2'd3, 1'b0, 1'b0, 1'b0, "rd_cnt3");
    repeat (3) cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "to9");
    cyc(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, "to9b");
    chk("count 9", 64'(count_o), 64'd9);
    cyc(2'd2, 2'd1, 1'b1, 1'b0, 1'b0, "flush");
    chk("flush count", 64'(count_o), 64'd0);
    x = nxt;
    cyc(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, "post_flush");
    chk("post_flush data", 64'(rd_data0_o), 64'(x));
    repeat (3) cyc(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "to7");
    chk("count 7", 64'(count_o), 64'd7);
    reset_i = 1'b0;
    cyc(2'd2, 2'd1, 1'b0, 1'b1, 1'b1, "reset_req");
    reset_i = 1'b1;
    chk("reset count", 64'(count_o), 64'd0);
    chk("reset empty", 64'(empty_o), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_dual.md
# fifo_dual

Two-wide, in-order, parametrised FIFO for the superscalar front end: up to two entries are enqueued and up to two dequeued per cycle. It sits between fetch/decode and dispatch as the instruction queue, and is reusable as any 2-wide buffer. Compared with the single-port FIFO it adds an exact occupancy count, all-or-nothing multi-entry handshakes, an almost-full flag and a pipeline flush.

## Interface
- WIDTH, 32, entry width in bits
- DEPTH, 16, number of entries; must equal 2**ADDR_LEN and be at least 4
- ADDR_LEN, 4, pointer width
- AF_THRESH, 2, almost_full_o asserts when free slots are fewer than AF_THRESH
- clk_i  in  1  clock, rising-edge
- reset_i  in  1  synchronous, active-low reset
- flush_i  in  1  discard all contents (mispredict/exception recovery)
- wr_cnt_i  in  2  entries to enqueue this cycle: 0, 1 or 2; 3 is illegal and treated as 0
- wr_data0_i  in  WIDTH  first (older) entry to enqueue
- wr_data1_i  in  WIDTH  second (younger) entry to enqueue
- rd_cnt_i  in  2  entries to dequeue this cycle: 0, 1 or 2; 3 is illegal and treated as 0
- wr_ack_o  out  1  combinational; the write request is accepted this cycle
- rd_ack_o  out  1  combinational; the read request is accepted this cycle
- rd_data0_o  out  WIDTH  head entry (asynchronous read)
- rd_data1_o  out  WIDTH  head+1 entry (asynchronous read)
- rd_valid0_o  out  1  count_o >= 1
- rd_valid1_o  out  1  count_o >= 2
- count_o  out  ADDR_LEN+1  occupancy, range 0..DEPTH
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- almost_full_o  out  1  (DEPTH - count_o) < AF_THRESH

## Operation
- State: wr_ptr, rd_ptr (ADDR_LEN bits, wrap modulo DEPTH), cnt (ADDR_LEN+1 bits), and the storage array. Storage is not reset.
- Write acceptance is all-or-nothing:
  - wr_ack_o = (wr_cnt_i != 0) && (DEPTH - cnt >= wr_cnt_i) && !flush_i.
  - Free space is taken from cnt at the start of the cycle. A same-cycle dequeue does not create space for a write.
  - A rejected write changes nothing. The producer holds its request.
- Accepted write:
  - mem[wr_ptr] <= wr_data0_i.
  - If wr_cnt_i == 2, also mem[wr_ptr+1] <= wr_data1_i (modulo DEPTH).
  - wr_ptr advances by wr_cnt_i.
- Read acceptance is all-or-nothing:
  - rd_ack_o = (rd_cnt_i != 0) && (cnt >= rd_cnt_i) && !flush_i.
  - Data written in the same cycle is not readable. There is no fall-through.
  - A rejected read leaves pointers and cnt unchanged.
- Accepted read: rd_ptr advances by rd_cnt_i. The consumer samples rd_data0_o/rd_data1_o in the same cycle it asserts rd_cnt_i.
- Count update: cnt <= cnt + (wr_ack ? wr_cnt_i : 0) - (rd_ack ? rd_cnt_i : 0). This is exact for every combination of 0/1/2 in and 0/1/2 out.
- Read data:
  - rd_data0_o = mem[rd_ptr] and rd_data1_o = mem[rd_ptr+1], with wrap modulo DEPTH.
  - Data is meaningful only when the matching rd_valid is set. Benches must gate their checks by valid.
- Flush, when flush_i = 1 and reset_i = 1:
  - Next cycle wr_ptr = rd_ptr = 0 and cnt = 0.
  - Flush overrides any same-cycle write or read. Both acks are forced to 0.
  - Storage contents are left untouched.
- Reset (reset_i = 0 at a rising edge):
  - Same state effect as flush. Reset has priority over flush.
  - The acks are still computed combinationally from pre-reset cnt and flush_i, but no state change is committed.

## Timing
- Write-to-read latency is 1 cycle. An entry written at edge N is visible on rd_data0_o (if it is the head) and counted in count_o after edge N.
- Flags are derived combinationally from the registered cnt:
  - empty_o, full_o, almost_full_o, rd_valid0_o, rd_valid1_o and count_o are all functions of the registered cnt.
  - None of them depends combinationally on wr_cnt_i or rd_cnt_i.
- Values after reset:
  - count_o = 0, empty_o = 1, full_o = 0.
  - almost_full_o = (DEPTH < AF_THRESH), i.e. 0 for legal parameters.
  - rd_valid0_o = rd_valid1_o = 0.
  - rd_data0_o and rd_data1_o are undefined.
- Acks are combinational from cnt, wr_cnt_i, rd_cnt_i and flush_i, and must settle within the same cycle.
- Wrap-around: a 2-entry write or read straddling index DEPTH-1 → 0 must split correctly (entry at DEPTH-1, next at 0).
- Boundary conditions:
  - When full, a read plus a write in the same cycle: the read is accepted and the write is rejected.
  - When empty, a read plus a write in the same cycle: the write is accepted and the read is rejected.

## Test plan
- Reset, then write 2 entries per cycle (A,B), (C,D) with DEPTH=16 → count_o = 4 after 2 cycles, rd_data0_o = A, rd_data1_o = B, valid1 = 1.
- Fill to count 15, then request a 2-entry write → wr_ack_o = 0 and count stays 15. A 1-entry write → count 16, full_o = 1. almost_full_o = 1 from count 15 onward.
- Count 1, request a 2-entry read → rd_ack_o = 0. Request a 1-entry read → count 0, empty_o = 1. Writing into an empty FIFO with a same-cycle read → write acked, read rejected.
- Steady state with 2 in and 2 out every cycle for 40 cycles across pointer wrap → count constant, output order matches input order exactly, including the pair straddling index 15 → 0.
- Count 9 with simultaneous write 2 and read 1 asserted together with flush_i → both acks 0, count_o = 0 next cycle, and a subsequent write of X is read back as rd_data0_o = X.
- Assert reset_i = 0 mid-stream at count 7 with active requests → count_o = 0, empty_o = 1 next cycle. wr_cnt_i = 3 → no ack and no state change.
